parking_gate_sequencer: RTL
===========================

// Module: parking_gate_sequencer
// PURPOSE
//  Upstream stage of the parking-lot occupancy counter. Debounces the entry/exit lane
//  sensors, latches each car's uni/public class, admits or rejects entries against the
//  counter's vacancy flags, and issues non-overlapping car_entered/car_exited pulses
//  with stable class bits. Also generates the hour-of-day count the counter consumes.
// PARAMETERS
//  TICKS_PER_HOUR   1000  clk cycles per hour increment (>=2)
//  DEBOUNCE_CYCLES  4     consecutive high samples needed to accept a sensor edge (>=1)
//  PULSE_CYCLES     2     width of car_entered/car_exited pulse, in clk cycles (>=1)
//  GAP_CYCLES       2     idle cycles after each pulse before the next event (>=1)
//  OPEN_HOUR        8     first hour in which entries are admitted
// PORTS
//  clk                   in   1  single clock, rising edge
//  rst_n                 in   1  asynchronous active-low reset
//  entry_sensor          in   1  raw entry-lane presence sensor (async, bouncy)
//  entry_is_uni          in   1  entry card class, valid while entry_sensor high
//  exit_sensor           in   1  raw exit-lane presence sensor
//  exit_is_uni           in   1  exit card class, valid while exit_sensor high
//  uni_is_vacated_space  in   1  counter: uni zone has space
//  is_vacated_space      in   1  counter: public zone has space
//  car_entered           out  1  entry event pulse to counter
//  is_uni_car_entered    out  1  class of the entry event
//  car_exited            out  1  exit event pulse to counter
//  is_uni_car_exited     out  1  class of the exit event
//  hour                  out  6  hour of day, 0..23
//  entry_gate_open       out  1  entry barrier open (high during accepted entry pulse)
//  exit_gate_open        out  1  exit barrier open (high during exit pulse)
//  entry_rejected        out  1  one-cycle pulse: entry refused
//  dropped_events        out  8  saturating count of events lost to a full lane slot
// BEHAVIOUR
//  Reset: all outputs 0, hour=0, tick=0, pending slots empty, FSM=IDLE; applies mid-pulse.
//  Inputs pass a 2-flop synchroniser first. Debounce: lane counter increments while
//   synced sensor high, clears when low; reaching DEBOUNCE_CYCLES generates one event
//   and latches class; no new event until sensor seen low again.
//  Each lane has a 1-deep pending slot {valid, is_uni}. Event while slot valid ->
//   event discarded, dropped_events+1 (saturate at 255).
//  Hour: tick counts 0..TICKS_PER_HOUR-1; on wrap hour+1, 23 -> 0. Free-running.
//  FSM IDLE -> SETUP -> PULSE -> GAP -> IDLE.
//   IDLE: exit slot valid has priority over entry slot. Exit: load is_uni_car_exited,
//    clear slot, go SETUP. Entry: evaluate admission with current hour/flags:
//    hour<OPEN_HOUR -> reject; uni -> admit if uni_is_vacated_space|is_vacated_space;
//    public -> admit if is_vacated_space. Reject: entry_rejected=1 one cycle, clear
//    slot, stay IDLE. Admit: load is_uni_car_entered, clear slot, go SETUP.
//   SETUP (1 cycle): class bit stable, pulses low (class set up before rising edge).
//   PULSE: car_entered or car_exited high PULSE_CYCLES cycles; matching gate_open high.
//   GAP: pulses low GAP_CYCLES cycles so counter flags settle; class bits held until
//    next SETUP loads a new value.
//  car_entered and car_exited never high in same cycle. Exits forwarded at any hour.
//  Slots keep collecting while FSM busy; simultaneous entry+exit -> exit first.
// TESTING
//  Reset, then run 8*TICKS_PER_HOUR cycles -> hour=8; 24 hours total -> hour wraps to 0.
//  hour=9, uni entry, both flags 1 -> SETUP 1 cycle, car_entered 2 cycles,
//   is_uni_car_entered=1, entry_gate_open high same cycles.
//  hour=5 public entry -> entry_rejected 1 cycle, no car_entered; hour=9, public,
//   is_vacated_space=0 -> rejected; uni with uni flag 0, public 1 -> admitted.
//  Entry and exit debounced same cycle -> car_exited first, GAP 2 cycles, then
//   car_entered; never overlapping.
//  Sensor glitch high 3 cycles (DEBOUNCE=4) -> no event; 3 entries while busy ->
//   one queued, dropped_events=1 (second after slot fills).
//  rst_n low during PULSE -> car_entered drops immediately, all outputs 0, slots empty.

Source files
------------

// File: rtl/parking_gate_sequencer.sv
// Purpose: debounce entry/exit lane sensors, admit or reject entries, and emit non-overlapping counter event pulses plus hour of day.
// Latency: raw sensor rise to event pulse is 2 sync + DEBOUNCE_CYCLES + 2 cycles (slot load, IDLE decision), then a 1-cycle SETUP.
// Backpressure: each lane holds one pending event while the sequencer is busy; further events on a full slot are dropped and counted.
module parking_gate_sequencer #(
    parameter int TICKS_PER_HOUR  = 1000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 2,
    parameter int OPEN_HOUR       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_sensor,
    input  logic       entry_is_uni,
    input  logic       exit_sensor,
    input  logic       exit_is_uni,
    input  logic       uni_is_vacated_space,
    input  logic       is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic [5:0] hour,
    output logic       entry_gate_open,
    output logic       exit_gate_open,
    output logic       entry_rejected,
    output logic [7:0] dropped_events
);

    localparam int TW         = $clog2(TICKS_PER_HOUR);
    localparam int DW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PMAX       = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PW         = $clog2(PMAX + 1);
    localparam int LANE_ENTRY = 0;
    localparam int LANE_EXIT  = 1;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, GAP} state_t;

    typedef struct packed {
        logic vld;
        logic is_uni;
    } slot_t;

    logic [1:0]         raw_sens, raw_cls;
    logic [1:0]         sens_s1, sens_s2, cls_s1, cls_s2;
    logic [1:0][DW-1:0] db_cnt;
    logic [1:0]         db_done;
    logic [1:0]         lane_evt;
    slot_t [1:0]        slot;
    logic [1:0]         slot_clr;
    logic [1:0]         drop;
    logic [8:0]         drop_sum;
    logic [TW-1:0]      tick;
    state_t             state, nxt_state;
    logic [PW-1:0]      phase_cnt;
    logic               cur_exit;
    logic               take_exit, take_entry, reject, entry_ok;

    assign raw_sens = {exit_sensor, entry_sensor};
    assign raw_cls  = {exit_is_uni, entry_is_uni};

    // Two-flop synchronisers for the asynchronous lane inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sens_s1 <= '0;
            sens_s2 <= '0;
            cls_s1  <= '0;
            cls_s2  <= '0;
        end else begin
            sens_s1 <= raw_sens;
            sens_s2 <= sens_s1;
            cls_s1  <= raw_cls;
            cls_s2  <= cls_s1;
        end
    end

    // One event per lane on the DEBOUNCE_CYCLES-th consecutive high sample.
    always_comb begin
        lane_evt = '0;
        for (int i = 0; i < 2; i++) begin
            lane_evt[i] = sens_s2[i] & ~db_done[i] & (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
        end
    end

    // Debounce counters; db_done blocks re-triggering until the sensor goes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt  <= '0;
            db_done <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!sens_s2[i]) begin
                    db_cnt[i]  <= '0;
                    db_done[i] <= 1'b0;
                end else if (lane_evt[i]) begin
                    db_done[i] <= 1'b1;
                end else if (!db_done[i]) begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    // An event that finds its slot occupied is lost and counted.
    always_comb begin
        drop     = {lane_evt[1] & slot[1].vld, lane_evt[0] & slot[0].vld};
        drop_sum = {1'b0, dropped_events} + {8'b0, drop[0]} + {8'b0, drop[1]};
    end

    // Pending slots and the saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot           <= '0;
            dropped_events <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (lane_evt[i] && !slot[i].vld) begin
                    slot[i].vld    <= 1'b1;
                    slot[i].is_uni <= cls_s2[i];
                end else if (slot_clr[i]) begin
                    slot[i].vld <= 1'b0;
                end
            end
            dropped_events <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Free-running hour-of-day clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
            hour <= '0;
        end else if (tick == TW'(TICKS_PER_HOUR - 1)) begin
            tick <= '0;
            hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        end else begin
            tick <= tick + TW'(1);
        end
    end

    // Uni cars may overflow into the public zone; nothing enters before opening hour.
    assign entry_ok = (hour >= 6'(OPEN_HOUR)) &&
                      (slot[LANE_ENTRY].is_uni ? (uni_is_vacated_space | is_vacated_space)
                                               : is_vacated_space);

    // Next-state and slot service; exit lane wins when both slots are pending.
    always_comb begin
        nxt_state  = state;
        slot_clr   = '0;
        take_exit  = 1'b0;
        take_entry = 1'b0;
        reject     = 1'b0;
        case (state)
            IDLE: begin
                if (slot[LANE_EXIT].vld) begin
                    take_exit           = 1'b1;
                    slot_clr[LANE_EXIT] = 1'b1;
                    nxt_state           = SETUP;
                end else if (slot[LANE_ENTRY].vld) begin
                    slot_clr[LANE_ENTRY] = 1'b1;
                    if (entry_ok) begin
                        take_entry = 1'b1;
                        nxt_state  = SETUP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            SETUP:   nxt_state = PULSE;
            PULSE:   if (phase_cnt == PW'(PULSE_CYCLES - 1)) nxt_state = GAP;
            GAP:     if (phase_cnt == PW'(GAP_CYCLES - 1)) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // State register, phase counter and latched event class bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            cur_exit           <= 1'b0;
            is_uni_car_entered <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            entry_rejected     <= 1'b0;
        end else begin
            state          <= nxt_state;
            entry_rejected <= reject;
            if (nxt_state != state) begin
                phase_cnt <= '0;
            end else if (state != IDLE) begin
                phase_cnt <= phase_cnt + PW'(1);
            end
            if (take_exit) begin
                cur_exit          <= 1'b1;
                is_uni_car_exited <= slot[LANE_EXIT].is_uni;
            end else if (take_entry) begin
                cur_exit           <= 1'b0;
                is_uni_car_entered <= slot[LANE_ENTRY].is_uni;
            end
        end
    end

    assign car_entered     = (state == PULSE) & ~cur_exit;
    assign car_exited      = (state == PULSE) &  cur_exit;
    assign entry_gate_open = car_entered;
    assign exit_gate_open  = car_exited;

endmodule
